// File: rtl/fir_interp2.sv
// -----------------------------------------------------------------------------
// fir_interp2 -- interpolate-by-2 symmetric FIR with a single shared multiplier.
//
// Each accepted input sample produces two output samples: one from the sample
// itself (data phase) and one from an inserted zero (zero phase). The FW-tap
// symmetric filter is evaluated with folded pairs, one multiply-accumulate per
// cycle, so an input occupies the block for 2*FN+3 cycles in total.
//
// Ports
//   Clk         clock, rising edge
//   Rstn        asynchronous active-low reset
//   Clear       synchronous clear, aborts any operation in progress
//   DataIn      signed input sample (DW bits)
//   DataInVld   input sample offered
//   DataInRdy   block can accept; transfer when DataInVld & DataInRdy
//   CoeffSel    coefficient bank select, captured at transfer
//   Coeff       two banks of FN signed folded coefficients, Coeff[bank][k]
//   DataOut     signed output sample, held between strobes
//   DataOutVld  one-cycle strobe per output sample (no backpressure)
//   dbg_state   {phase, fsm state} for observation (IDLE=0, MAC=1, OUT=2)
//
// Handshake: a sample moves on a rising edge where DataInVld and DataInRdy are
// both high. DataInRdy depends only on the FSM state, never on DataInVld.
// -----------------------------------------------------------------------------
module fir_interp2 #(
    parameter int DW = 10,
    parameter int CW = 10,
    parameter int FW = 7,
    parameter int SL = 7
) (
    input  logic                                  Clk,
    input  logic                                  Rstn,
    input  logic                                  Clear,
    input  logic signed [DW-1:0]                  DataIn,
    input  logic                                  DataInVld,
    output logic                                  DataInRdy,
    input  logic                                  CoeffSel,
    input  logic [1:0][(FW+1)/2-1:0][CW-1:0]      Coeff,
    output logic signed [DW-1:0]                  DataOut,
    output logic                                  DataOutVld,
    output logic [2:0]                            dbg_state
);

    localparam int FN   = (FW + 1) / 2;
    localparam int AW   = DW + CW + $clog2(FW) + 1;
    localparam int PW   = DW + 1 + CW;
    localparam int CNTW = (FN > 1) ? $clog2(FN) : 1;

    localparam logic [CNTW-1:0]     CNT_LAST = CNTW'(FN - 1);
    localparam logic signed [AW-1:0] OUT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] OUT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic signed [DW-1:0]   tap [FW];
    logic                   phase;
    logic [CNTW-1:0]        cnt;
    logic                   bank;
    logic signed [AW-1:0]   acc;

    logic signed [DW-1:0]   near_tap;
    logic signed [DW-1:0]   far_tap;
    logic signed [DW:0]     pair;
    logic signed [CW-1:0]   coef;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   acc_sum;
    logic signed [AW-1:0]   shifted;
    logic signed [DW-1:0]   sat_val;

    assign DataInRdy  = (state == S_IDLE);
    // A Clear arriving in the OUT cycle discards that output as well.
    assign DataOutVld = (state == S_OUT) && !Clear;
    assign dbg_state  = {phase, state};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (DataInVld)        state_nxt = S_MAC;
            S_MAC:   if (cnt == CNT_LAST)  state_nxt = S_OUT;
            S_OUT:   state_nxt = phase ? S_IDLE : S_MAC;
            default: state_nxt = S_IDLE;
        endcase
        if (Clear) begin
            state_nxt = S_IDLE;
        end
    end

    // ---------------------------------------------------------- MAC term
    // Folded pair k is tap[k] + tap[FW-1-k]; the centre tap has no partner.
    always_comb begin
        near_tap = '0;
        far_tap  = '0;
        for (int i = 0; i < FN; i++) begin
            if (cnt == CNTW'(i)) begin
                near_tap = tap[i];
                far_tap  = (i == FN - 1) ? '0 : tap[FW-1-i];
            end
        end
        pair    = {near_tap[DW-1], near_tap} + {far_tap[DW-1], far_tap};
        // Coefficients are read live so a change only affects terms not yet summed.
        coef    = $signed(Coeff[bank][cnt]);
        prod    = pair * coef;
        acc_sum = acc + AW'(prod);
        shifted = acc_sum >>> SL;
        if (shifted > OUT_MAX) begin
            sat_val = OUT_MAX[DW-1:0];
        end else if (shifted < OUT_MIN) begin
            sat_val = OUT_MIN[DW-1:0];
        end else begin
            sat_val = shifted[DW-1:0];
        end
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            for (int i = 0; i < FW; i++) tap[i] <= '0;
            acc     <= '0;
            phase   <= 1'b0;
            cnt     <= '0;
            bank    <= 1'b0;
            DataOut <= '0;
        end else if (Clear) begin
            for (int i = 0; i < FW; i++) tap[i] <= '0;
            acc     <= '0;
            phase   <= 1'b0;
            cnt     <= '0;
            DataOut <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (DataInVld) begin
                        tap[0] <= DataIn;
                        for (int i = 1; i < FW; i++) tap[i] <= tap[i-1];
                        bank  <= CoeffSel;
                        phase <= 1'b0;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                S_MAC: begin
                    acc <= acc_sum;
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        // Result is registered on the last MAC so it is
                        // already stable during the OUT strobe cycle.
                        DataOut <= sat_val;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_OUT: begin
                    if (!phase) begin
                        tap[0] <= '0;
                        for (int i = 1; i < FW; i++) tap[i] <= tap[i-1];
                        phase <= 1'b1;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/fir_interp2.md
FIR_INTERP2 -- requirements
Module: fir_interp2

Interface
REQ-001 SHALL have parameter DW, default 10, signed sample width in and out.
REQ-002 SHALL have parameter CW, default 10, signed coefficient width.
REQ-003 SHALL have parameter FW, default 7, tap count; odd, >= 3; FN = (FW+1)/2 folded coefficients.
REQ-004 SHALL have parameter SL, default 7, arithmetic right shift applied to the accumulator before saturation.
REQ-005 SHALL use one clock and an asynchronous active-low reset, as listed next.
REQ-006 SHALL have port Clk  input  1  clock; all state changes on rising edge.
REQ-007 SHALL have port Rstn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port Clear  input  1  synchronous clear; aborts any operation.
REQ-009 SHALL have port DataIn  input  DW  signed input sample.
REQ-010 SHALL have port DataInVld  input  1  sample offered.
REQ-011 SHALL have port DataInRdy  output  1  block can accept; transfer when DataInVld & DataInRdy.
REQ-012 SHALL have port CoeffSel  input  1  coefficient bank select, sampled at transfer.
REQ-013 SHALL have port Coeff  input  2 x FN x CW  two banks of FN signed coefficients; Coeff[b][k] is the folded tap k.
REQ-014 SHALL have port DataOut  output  DW  signed output sample.
REQ-015 SHALL have port DataOutVld  output  1  one-cycle strobe per output sample; no backpressure.

Function
REQ-016 SHALL interpolate by 2: each accepted input yields two outputs, from the input followed by one inserted zero, through a symmetric FW-tap FIR.
REQ-017 SHALL keep delay line tap[0..FW-1], with tap[0] newest; a push shifts by one and loads tap[0].
REQ-018 SHALL form folded pair k (k < FN-1) as tap[k] + tap[FW-1-k] at DW+1 bits, and middle term k = FN-1 as tap[FN-1] alone.
REQ-019 SHALL use an accumulator of DW+CW+clog2(FW)+1 signed bits, cleared at the start of each output computation.
REQ-020 SHALL set output = (acc >>> SL), saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-021 SHALL implement FSM states IDLE, MAC, OUT with a phase bit (0 = data phase, 1 = zero phase).
REQ-022 In IDLE, DataInRdy SHALL be 1; on transfer: push DataIn, latch CoeffSel, phase=0, counter=0, go to MAC.
REQ-023 In MAC, the block SHALL perform one multiply-accumulate per cycle for k = 0..FN-1, then go to OUT after FN cycles.
REQ-024 In OUT, DataOutVld=1 and DataOut SHALL be updated; if phase=0: push zero, phase=1, go to MAC; if phase=1: go to IDLE.
REQ-025 DataInRdy SHALL be 0 in MAC and OUT; DataInVld there is ignored and not stored.
REQ-026 First output SHALL be valid FN+1 cycles after the transfer cycle, and the second 2*FN+2 cycles after it; DataInRdy returns 1 2*FN+3 cycles after it.
REQ-027 DataOut SHALL hold its last value between strobes.
REQ-028 Clear SHALL have priority over all FSM actions: taps, accumulator, phase and counter go to 0, state goes to IDLE, DataOutVld=0, DataOut=0; any partial output is discarded.
REQ-029 Clear together with DataInVld in IDLE SHALL not accept the sample.
REQ-030 Coeff changes during MAC SHALL affect only folded terms not yet accumulated; the bank is fixed per input.

Reset
REQ-031 Rstn low SHALL asynchronously set: state IDLE, DataInRdy=1, DataOutVld=0, DataOut=0, taps=0, accumulator=0, phase=0, counter=0, bank=0.
REQ-032 Reset asserted mid-MAC SHALL drop the operation with no output strobe; after release the block behaves as from power-up.

Verification
REQ-033 Setup FW=7, SL=0, bank0 Coeff = {1,2,3,4}; input impulse 1, then six zeros -> outputs 1,2,3,4,3,2,1,0,... then all 0.
REQ-034 Setup DW=10, CW=10, SL=0, all coeffs 511; constant input 511 -> output saturates to 511; constant input -512 -> output saturates to -512.
REQ-035 Hold DataInVld=1 continuously with samples 5,6,7 -> exactly one transfer per 2*FN+3 cycles, samples in order, none skipped or duplicated.
REQ-036 Assert Clear in MAC cycle 2 of the first phase -> no DataOutVld, DataInRdy=1 next cycle, and a following impulse test reproduces REQ-033 exactly.
REQ-037 Bank0 = {1,2,3,4}, bank1 = {4,3,2,1}; impulse with CoeffSel=1 -> outputs 4,3,2,1,2,3,4.
REQ-038 Deassert Rstn during the second MAC phase -> outputs clear immediately, no strobe, DataInRdy=1 while Rstn is low.
